// File: rtl/hk_round_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Package     : sha256_pkg
// Description : Shared types and constants for the SHA-256 H/K sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package sha256_pkg;

    localparam int H_WORDS  = 8;
    localparam int K_WORDS  = 64;
    localparam int HK_TOTAL = H_WORDS + K_WORDS;

    localparam logic SEL_H = 1'b0;
    localparam logic SEL_K = 1'b1;

    localparam int FIFO_W = 41;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COPY    = 3'd1,
        FETCH_H = 3'd2,
        FETCH_K = 3'd3,
        DRAIN   = 3'd4
    } hk_state_e;

    typedef struct packed {
        logic        spare;
        logic [31:0] word;
        logic        is_k;
        logic [5:0]  idx;
        logic        last;
    } hk_entry_t;

    // H and K words share one 6-bit index field in the stream.
    function automatic logic [5:0] hk_word_idx(input logic sel,
                                               input logic [2:0] h_addr,
                                               input logic [5:0] k_addr);
        return (sel == SEL_K) ? k_addr : {3'b000, h_addr};
    endfunction

endpackage
`default_nettype wire

// File: rtl/hk_round_sequencer_if.sv
`default_nettype none
// ============================================================================
// Interface   : hk_round_sequencer_if
// Description : Memory-control and word-stream signals of the H/K sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface hk_round_sequencer_if;

    logic        START;
    logic        COPY_ROM;
    logic        MEM_RDY;
    logic        HK_SELECTOR;
    logic [2:0]  H_ADDR;
    logic [5:0]  K_ADDR;
    logic [31:0] HK;
    logic [31:0] WORD;
    logic        WORD_VALID;
    logic        WORD_READY;
    logic        WORD_IS_K;
    logic [5:0]  WORD_IDX;
    logic        WORD_LAST;
    logic        BUSY;
    logic        DONE;

    modport master (
        input  START, MEM_RDY, HK, WORD_READY,
        output COPY_ROM, HK_SELECTOR, H_ADDR, K_ADDR,
               WORD, WORD_VALID, WORD_IS_K, WORD_IDX, WORD_LAST, BUSY, DONE
    );

    modport slave (
        output START, MEM_RDY, HK, WORD_READY,
        input  COPY_ROM, HK_SELECTOR, H_ADDR, K_ADDR,
               WORD, WORD_VALID, WORD_IS_K, WORD_IDX, WORD_LAST, BUSY, DONE
    );

endinterface
`default_nettype wire

// File: rtl/hk_round_sequencer_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module      : hk_skid_fifo
// Description : Two-entry register FIFO buffering words read from the memory.
// Revision    : 1.0 - initial release
// ============================================================================
module hk_skid_fifo
    import sha256_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_push,
    input  wire logic [FIFO_W-1:0] i_data,
    input  wire logic              i_pop,
    output logic      [1:0]        o_count,
    output logic      [FIFO_W-1:0] o_head
);

    logic [FIFO_W-1:0] r_mem_q [2];
    logic [FIFO_W-1:0] w_mem_d [2];
    logic              r_wr_ptr_q, w_wr_ptr_d;
    logic              r_rd_ptr_q, w_rd_ptr_d;
    logic [1:0]        r_count_q,  w_count_d;

    always_comb begin
        w_mem_d    = r_mem_q;
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_count_d  = r_count_q;
        if (i_push) begin
            w_mem_d[r_wr_ptr_q] = i_data;
            w_wr_ptr_d          = ~r_wr_ptr_q;
        end
        if (i_pop) begin
            w_rd_ptr_d = ~r_rd_ptr_q;
        end
        case ({i_push, i_pop})
            2'b10:   w_count_d = r_count_q + 2'd1;
            2'b01:   w_count_d = r_count_q - 2'd1;
            default: w_count_d = r_count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_q[0] <= '0;
            r_mem_q[1] <= '0;
            r_wr_ptr_q <= 1'b0;
            r_rd_ptr_q <= 1'b0;
            r_count_q  <= 2'd0;
        end else begin
            r_mem_q    <= w_mem_d;
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_count_q  <= w_count_d;
        end
    end

    assign o_count = r_count_q;
    assign o_head  = r_mem_q[r_rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/hk_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : hk_round_sequencer
// Description : Runs the H/K ROM-to-RAM copy once, then streams H0..7, K0..63.
// Revision    : 1.0 - initial release
// ============================================================================
module hk_round_sequencer
    import sha256_pkg::*;
(
    input wire logic              CLK,
    input wire logic              RST,
    hk_round_sequencer_if.master  bus
);

    hk_state_e  r_state_q,    w_state_d;
    logic       r_copied_q,   w_copied_d;
    logic       r_copy_rom_q, w_copy_rom_d;
    logic       r_busy_q,     w_busy_d;
    logic       r_done_q,     w_done_d;
    logic [6:0] r_cnt_q,      w_cnt_d;
    logic       r_inflight_q, w_inflight_d;
    logic       r_sel_q,      w_sel_d;
    logic [2:0] r_h_addr_q,   w_h_addr_d;
    logic [5:0] r_k_addr_q,   w_k_addr_d;

    logic [1:0] w_fifo_count;
    hk_entry_t  w_head;
    hk_entry_t  w_push_entry;
    logic       w_word_valid;
    logic       w_pop;
    logic       w_fetching;
    logic [2:0] w_occupancy;
    logic       w_issue;
    logic       w_issue_sel;
    logic [2:0] w_issue_h;
    logic [6:0] w_k_offset;
    logic [5:0] w_issue_k;
    logic       w_fifo_drained;
    logic       w_unused_spare;

    assign w_word_valid = (w_fifo_count != 2'd0);
    assign w_pop        = w_word_valid & bus.WORD_READY;
    assign w_fetching   = (r_state_q == FETCH_H) || (r_state_q == FETCH_K);

    // A read may only be issued if the FIFO is guaranteed a free slot when it lands.
    assign w_occupancy  = {1'b0, w_fifo_count} + {2'b00, r_inflight_q} - {2'b00, w_pop};
    assign w_issue      = w_fetching && (w_occupancy < 3'd2);

    assign w_issue_sel  = (r_cnt_q >= 7'(H_WORDS)) ? SEL_K : SEL_H;
    assign w_issue_h    = r_cnt_q[2:0];
    assign w_k_offset   = r_cnt_q - 7'(H_WORDS);
    assign w_issue_k    = w_k_offset[5:0];

    assign w_fifo_drained = (w_fifo_count == 2'd0) || ((w_fifo_count == 2'd1) && w_pop);

    // The last-issued address registers describe the read that is in flight.
    always_comb begin
        w_push_entry       = '0;
        w_push_entry.word  = bus.HK;
        w_push_entry.is_k  = r_sel_q;
        w_push_entry.idx   = hk_word_idx(r_sel_q, r_h_addr_q, r_k_addr_q);
        w_push_entry.last  = (r_sel_q == SEL_K) && (r_k_addr_q == 6'(K_WORDS - 1));
    end

    hk_skid_fifo u_fifo (
        .clk     (CLK),
        .rst     (RST),
        .i_push  (r_inflight_q),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_count (w_fifo_count),
        .o_head  (w_head)
    );

    assign w_unused_spare = w_head.spare;

    always_comb begin
        w_state_d    = r_state_q;
        w_copied_d   = r_copied_q;
        w_copy_rom_d = r_copy_rom_q;
        w_done_d     = 1'b0;
        w_cnt_d      = r_cnt_q;
        w_inflight_d = w_issue;
        w_sel_d      = r_sel_q;
        w_h_addr_d   = r_h_addr_q;
        w_k_addr_d   = r_k_addr_q;

        if (w_issue) begin
            w_sel_d    = w_issue_sel;
            w_h_addr_d = w_issue_h;
            w_k_addr_d = w_issue_k;
            w_cnt_d    = r_cnt_q + 7'd1;
        end

        case (r_state_q)
            IDLE: begin
                if (bus.START) begin
                    w_cnt_d = 7'd0;
                    if (r_copied_q) begin
                        w_state_d = FETCH_H;
                    end else begin
                        w_state_d    = COPY;
                        w_copy_rom_d = 1'b1;
                    end
                end
            end
            COPY: begin
                if (bus.MEM_RDY) begin
                    w_copied_d   = 1'b1;
                    w_copy_rom_d = 1'b0;
                    w_state_d    = FETCH_H;
                end
            end
            FETCH_H: begin
                if (w_issue && (r_cnt_q == 7'(H_WORDS - 1))) begin
                    w_state_d = FETCH_K;
                end
            end
            FETCH_K: begin
                if (w_issue && (r_cnt_q == 7'(HK_TOTAL - 1))) begin
                    w_state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!r_inflight_q && w_fifo_drained) begin
                    w_state_d = IDLE;
                    w_done_d  = 1'b1;
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase

        w_busy_d = (w_state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state_q    <= IDLE;
            r_copied_q   <= 1'b0;
            r_copy_rom_q <= 1'b0;
            r_busy_q     <= 1'b0;
            r_done_q     <= 1'b0;
            r_cnt_q      <= 7'd0;
            r_inflight_q <= 1'b0;
            r_sel_q      <= SEL_H;
            r_h_addr_q   <= 3'd0;
            r_k_addr_q   <= 6'd0;
        end else begin
            r_state_q    <= w_state_d;
            r_copied_q   <= w_copied_d;
            r_copy_rom_q <= w_copy_rom_d;
            r_busy_q     <= w_busy_d;
            r_done_q     <= w_done_d;
            r_cnt_q      <= w_cnt_d;
            r_inflight_q <= w_inflight_d;
            r_sel_q      <= w_sel_d;
            r_h_addr_q   <= w_h_addr_d;
            r_k_addr_q   <= w_k_addr_d;
        end
    end

    assign bus.COPY_ROM    = r_copy_rom_q;
    assign bus.HK_SELECTOR = w_issue ? w_issue_sel : r_sel_q;
    assign bus.H_ADDR      = w_issue ? w_issue_h   : r_h_addr_q;
    assign bus.K_ADDR      = w_issue ? w_issue_k   : r_k_addr_q;
    assign bus.WORD        = w_head.word;
    assign bus.WORD_VALID  = w_word_valid;
    assign bus.WORD_IS_K   = w_head.is_k;
    assign bus.WORD_IDX    = w_head.idx;
    assign bus.WORD_LAST   = w_head.last;
    assign bus.BUSY        = r_busy_q;
    assign bus.DONE        = r_done_q;

endmodule
`default_nettype wire

// File: tb/tb_hk_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_hk_round_sequencer
// Description : Self-checking bench with a behavioural H/K memory and stream model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hk_round_sequencer;
    import sha256_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    hk_round_sequencer_if bus ();

    hk_round_sequencer dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.master)
    );

    logic [31:0] H_TAB [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    // Memory model: address captured at the edge, data readable the following cycle.
    logic       mem_copied = 1'b0;
    logic       mem_sel_q  = 1'b0;
    logic [2:0] mem_h_q    = 3'd0;
    logic [5:0] mem_k_q    = 6'd0;

    always @(posedge CLK) begin
        mem_sel_q <= bus.HK_SELECTOR;
        mem_h_q   <= bus.H_ADDR;
        mem_k_q   <= bus.K_ADDR;
    end

    assign bus.HK = !mem_copied ? 32'hdeadbeef : (mem_sel_q ? K_TAB[mem_k_q] : H_TAB[mem_h_q]);

    typedef struct {
        int rdy_delay;
        int ready_pct;
        bit mid_start;
        bit exp_copy;
        int exp_latency;
    } scenario_t;

    scenario_t scen [5];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Stream position i -> {word, is_k, idx, last}
    function automatic logic [39:0] ref_word(input int i);
        logic        is_k;
        logic [5:0]  idx;
        logic [31:0] w;
        is_k = (i >= 8);
        idx  = is_k ? 6'(i - 8) : 6'(i);
        w    = is_k ? K_TAB[i - 8] : H_TAB[i];
        return {w, is_k, idx, (i == 71)};
    endfunction

    function automatic logic [39:0] head_now();
        return {bus.WORD, bus.WORD_IS_K, bus.WORD_IDX, bus.WORD_LAST};
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, " COPY_ROM"},    40'(bus.COPY_ROM),    40'd0);
        check({tag, " HK_SELECTOR"}, 40'(bus.HK_SELECTOR), 40'd0);
        check({tag, " H_ADDR"},      40'(bus.H_ADDR),      40'd0);
        check({tag, " K_ADDR"},      40'(bus.K_ADDR),      40'd0);
        check({tag, " WORD"},        40'(bus.WORD),        40'd0);
        check({tag, " WORD_VALID"},  40'(bus.WORD_VALID),  40'd0);
        check({tag, " WORD_IS_K"},   40'(bus.WORD_IS_K),   40'd0);
        check({tag, " WORD_IDX"},    40'(bus.WORD_IDX),    40'd0);
        check({tag, " WORD_LAST"},   40'(bus.WORD_LAST),   40'd0);
        check({tag, " BUSY"},        40'(bus.BUSY),        40'd0);
        check({tag, " DONE"},        40'(bus.DONE),        40'd0);
    endtask

    task automatic run_stream(input scenario_t sc, input string tag);
        int          cyc         = 0;
        int          pos         = 0;
        int          first_valid = -1;
        int          copy_seen   = 0;
        int          done_cnt    = 0;
        int          last_pop    = -1;
        int          post        = 0;
        bit          stalled     = 1'b0;
        bit          done_flag   = 1'b0;
        logic [39:0] held        = '0;
        bus.START      = 1'b1;
        bus.WORD_READY = ($urandom_range(99) < sc.ready_pct);
        while (1) begin
            @(posedge CLK);
            @(negedge CLK);
            cyc++;
            if (cyc == 1) begin
                bus.START = 1'b0;
                check({tag, " copy_rom_first"}, 40'(bus.COPY_ROM), 40'(sc.exp_copy));
                check({tag, " busy_first"},     40'(bus.BUSY),     40'd1);
            end
            if (sc.mid_start) bus.START = (cyc == 20);
            if (bus.COPY_ROM) copy_seen++;
            if (bus.COPY_ROM && copy_seen > sc.rdy_delay) begin
                mem_copied  = 1'b1;
                bus.MEM_RDY = 1'b1;
            end
            if (bus.WORD_VALID && first_valid < 0) begin
                first_valid = cyc;
                check({tag, " latency"}, 40'(first_valid), 40'(sc.exp_latency));
            end
            if (stalled) check({tag, " stall_hold"}, {bus.WORD_VALID, head_now()}, {1'b1, held});
            if (bus.DONE) begin
                done_cnt++;
                done_flag = 1'b1;
                check({tag, " done_timing"}, 40'(cyc), 40'(last_pop + 1));
                check({tag, " busy_at_done"}, 40'(bus.BUSY), 40'd0);
            end
            bus.WORD_READY = ($urandom_range(99) < sc.ready_pct);
            if (bus.WORD_VALID && bus.WORD_READY) begin
                if (pos < HK_TOTAL) begin
                    check($sformatf("%s word%0d", tag, pos), head_now(), ref_word(pos));
                end else begin
                    check({tag, " extra_word"}, 40'(pos), 40'(HK_TOTAL - 1));
                end
                pos++;
                last_pop = cyc;
            end
            stalled = bus.WORD_VALID && !bus.WORD_READY;
            held    = head_now();
            if (done_flag) post++;
            if (post == 4) break;
            if (cyc > 3000) begin
                check({tag, " timeout"}, 40'(cyc), 40'd3000);
                break;
            end
        end
        check({tag, " word_count"}, 40'(pos),       40'(HK_TOTAL));
        check({tag, " done_count"}, 40'(done_cnt),  40'd1);
        check({tag, " copy_cycles"}, 40'(copy_seen), sc.exp_copy ? 40'(sc.rdy_delay + 1) : 40'd0);
        check({tag, " idle_after"}, {38'd0, bus.BUSY, bus.WORD_VALID}, 40'd0);
        if (sc.ready_pct == 100) begin
            check({tag, " contiguous"}, 40'(last_pop - first_valid + 1), 40'(HK_TOTAL));
        end
    endtask

    initial begin
        bit hit = 1'b0;
        int pos = 0;

        scen[0] = '{rdy_delay: 5, ready_pct: 100, mid_start: 1'b0, exp_copy: 1'b1, exp_latency: 9};
        scen[1] = '{rdy_delay: 0, ready_pct: 100, mid_start: 1'b0, exp_copy: 1'b0, exp_latency: 3};
        scen[2] = '{rdy_delay: 0, ready_pct: 50,  mid_start: 1'b0, exp_copy: 1'b0, exp_latency: 3};
        scen[3] = '{rdy_delay: 0, ready_pct: 70,  mid_start: 1'b1, exp_copy: 1'b0, exp_latency: 3};
        scen[4] = '{rdy_delay: 0, ready_pct: 30,  mid_start: 1'b0, exp_copy: 1'b0, exp_latency: 3};

        bus.START      = 1'b0;
        bus.MEM_RDY    = 1'b0;
        bus.WORD_READY = 1'b0;
        RST            = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_reset_outputs("reset");
        RST = 1'b0;
        @(negedge CLK);

        for (int s = 0; s < 5; s++) begin
            run_stream(scen[s], $sformatf("scen%0d", s));
        end

        // Reset in the middle of the K phase, then a fresh start must recopy.
        bus.START      = 1'b1;
        bus.WORD_READY = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(posedge CLK);
            @(negedge CLK);
            bus.START = 1'b0;
            if (bus.WORD_VALID) begin
                if (pos == 28) begin
                    check("rst_mid k20_head", head_now(), ref_word(28));
                    RST         = 1'b1;
                    mem_copied  = 1'b0;
                    bus.MEM_RDY = 1'b0;
                    hit         = 1'b1;
                    break;
                end
                pos++;
            end
        end
        if (!hit) check("rst_mid reach_k20", 40'(pos), 40'd28);
        @(posedge CLK);
        @(negedge CLK);
        check_reset_outputs("rst_mid");
        RST            = 1'b0;
        bus.WORD_READY = 1'b0;
        @(negedge CLK);
        run_stream('{rdy_delay: 2, ready_pct: 100, mid_start: 1'b0, exp_copy: 1'b1, exp_latency: 6}, "restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
